// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port NoC router.
//   - Input port indices (N, S, E, W, Local) as used on req/grant vectors.
//   - NO_GRANT: grant index reported when no input holds the output.
//   - PKT_FLITS_DEF: default fixed packet length in flits, head included.
//   - sched_state_e: output scheduler FSM states.
package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam logic [2:0] NO_GRANT = 3'b111;

  localparam int PKT_FLITS_DEF = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans elig starting at ptr+1 and wrapping modulo N; the first set bit wins.
// Ports:
//   elig         in  N  eligible requesters
//   ptr          in  3  index of the previous winner (lowest priority now)
//   gnt          out N  one-hot winner, 0 when nothing is eligible
//   idx          out 3  winner index, NO_GRANT when nothing is eligible
//   any_eligible out 1  at least one eligible requester
module rr_pick
  import noc_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] elig,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         any_eligible
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = NO_GRANT;
    found = 1'b0;
    cand  = '0;
    // off = N lands back on ptr itself, so the previous winner is checked last.
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        idx       = 3'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

  assign any_eligible = |elig;

endmodule

// File: rtl/out_port_sched.sv
// Per-output-port scheduler: round-robin arbitration among the input ports
// requesting this output, grant locked for one fixed-length packet, and each
// flit gated on downstream credits.
//
// Handshake: send_o acts as ready and flit_valid_i as valid. A flit moves in
// any cycle where both are high. send_o never depends on flit_valid_i, and
// flit_valid_i is ignored whenever send_o is low.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_i         per-input request (bit 0 = N, 1 = S, 2 = E, 3 = W, 4 = L)
//   mask_i        1 = input may not win a new grant
//   flit_valid_i  granted input presents a flit
//   credit_ret_i  downstream freed one buffer slot
//   grant_o       registered one-hot grant
//   grant_idx_o   granted index, NO_GRANT when idle
//   send_o        flit transfer permitted this cycle
//   busy_o        packet lock held
//   credit_cnt_o  current downstream credits
//   credit_err_o  sticky credit-overflow flag, cleared only by rst
//   state_o       debug view of the FSM state (0 = IDLE, 1 = LOCK)
module out_port_sched
  import noc_pkg::*;
#(
  parameter int N_IN      = 5,
  parameter int PKT_FLITS = PKT_FLITS_DEF,
  parameter int CREDITS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN-1:0]              req_i,
  input  logic [N_IN-1:0]              mask_i,
  input  logic                         flit_valid_i,
  input  logic                         credit_ret_i,
  output logic [N_IN-1:0]              grant_o,
  output logic [2:0]                   grant_idx_o,
  output logic                         send_o,
  output logic                         busy_o,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic                         credit_err_o,
  output logic [0:0]                   state_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int FW = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;

  localparam logic [0:0]    ST_IDLE   = IDLE;
  localparam logic [0:0]    ST_LOCK   = LOCK;
  localparam logic [FW-1:0] LAST_FLIT = FW'(PKT_FLITS - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

  logic [0:0]      state_q;
  logic [N_IN-1:0] grant_q;
  logic [2:0]      grant_idx_q;
  logic [2:0]      ptr_q;
  logic [FW-1:0]   flit_cnt_q;
  logic [CW-1:0]   credit_cnt_q;
  logic            credit_err_q;

  logic [N_IN-1:0] elig;
  logic [N_IN-1:0] pick_gnt;
  logic [2:0]      pick_idx;
  logic            pick_any;
  logic            send;
  logic            xfer;

  assign elig = req_i & ~mask_i;

  rr_pick #(
    .N (N_IN)
  ) u_pick (
    .elig         (elig),
    .ptr          (ptr_q),
    .gnt          (pick_gnt),
    .idx          (pick_idx),
    .any_eligible (pick_any)
  );

  // Ready is a pure function of registered state, so a credit returned in
  // cycle t can only enable sending from cycle t+1.
  assign send = (state_q == ST_LOCK) && (credit_cnt_q != '0);
  assign xfer = send && flit_valid_i;

  // Arbitration FSM. The picker is only consulted in IDLE, so req_i/mask_i
  // changes during a packet are invisible until the lock drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= NO_GRANT;
      ptr_q       <= 3'(N_IN - 1);
      flit_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q     <= ST_LOCK;
            grant_q     <= pick_gnt;
            grant_idx_q <= pick_idx;
            flit_cnt_q  <= '0;
          end
        end
        ST_LOCK: begin
          if (xfer) begin
            if (flit_cnt_q == LAST_FLIT) begin
              // Dropping to IDLE for one cycle gives the mandatory gap
              // between packets; the winner becomes lowest priority.
              state_q     <= ST_IDLE;
              grant_q     <= '0;
              grant_idx_q <= NO_GRANT;
              ptr_q       <= grant_idx_q;
              flit_cnt_q  <= '0;
            end else begin
              flit_cnt_q <= flit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          grant_q     <= '0;
          grant_idx_q <= NO_GRANT;
        end
      endcase
    end
  end

  // Credit counter. A transfer and a return in the same cycle cancel out.
  // A return with the counter already full is a downstream protocol error:
  // the count saturates and the sticky flag records it.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_q <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      if (xfer && !credit_ret_i) begin
        credit_cnt_q <= credit_cnt_q - 1'b1;
      end else if (credit_ret_i && !xfer) begin
        if (credit_cnt_q == CRED_MAX) begin
          credit_err_q <= 1'b1;
        end else begin
          credit_cnt_q <= credit_cnt_q + 1'b1;
        end
      end
    end
  end

  assign grant_o      = grant_q;
  assign grant_idx_o  = grant_idx_q;
  assign send_o       = send;
  assign busy_o       = (state_q == ST_LOCK);
  assign credit_cnt_o = credit_cnt_q;
  assign credit_err_o = credit_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_out_port_sched.sv
// Bench for out_port_sched. The stimulus process drives one cycle at a time
// and advances a behavioural model (packet owner, flits sent, credits, last
// winner). Before each cycle it pushes the outputs the model predicts for
// that cycle, and pushes the winner of every new grant. A monitor samples on
// the falling edge and pops/compares.
module tb_out_port_sched;
  import noc_pkg::*;

  localparam int N_IN = 5;
  localparam int PKT  = 5;
  localparam int CRED = 4;
  localparam int CW   = $clog2(CRED + 1);
  // Word layout, MSB first: busy, send, idx[2:0], cred[CW-1:0], err, grant[N_IN-1:0]
  localparam int W    = 1 + 1 + 3 + CW + 1 + N_IN;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [N_IN-1:0] req_i;
  logic [N_IN-1:0] mask_i;
  logic            flit_valid_i;
  logic            credit_ret_i;
  logic [N_IN-1:0] grant_o;
  logic [2:0]      grant_idx_o;
  logic            send_o;
  logic            busy_o;
  logic [CW-1:0]   credit_cnt_o;
  logic            credit_err_o;
  logic [0:0]      state_o;

  always #5 clk = ~clk;

  out_port_sched #(
    .N_IN      (N_IN),
    .PKT_FLITS (PKT),
    .CREDITS   (CRED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .mask_i       (mask_i),
    .flit_valid_i (flit_valid_i),
    .credit_ret_i (credit_ret_i),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .send_o       (send_o),
    .busy_o       (busy_o),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           gnt_q[$];
  int           obs_g[$];
  int           exp_g[$];
  int           checks = 0;
  int           errors = 0;

  // ---------------- reference model ----------------
  bit m_busy;
  bit m_err;
  int m_owner;
  int m_sent;
  int m_cred;
  int m_last;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_owner = 0;
    m_sent  = 0;
    m_cred  = CRED;
    m_last  = N_IN - 1;
  endtask

  function automatic logic [W-1:0] model_word();
    logic [N_IN-1:0] g;
    logic [2:0]      ix;
    g  = '0;
    ix = 3'd7;
    if (m_busy) begin
      g[m_owner] = 1'b1;
      ix         = 3'(m_owner);
    end
    return {m_busy, (m_busy && m_cred > 0), ix, CW'(m_cred), m_err, g};
  endfunction

  function automatic string fmt(input logic [W-1:0] w);
    return $sformatf("busy=%b send=%b idx=%0d cred=%0d err=%b gnt=%b",
                     w[W-1], w[W-2], w[W-3 -: 3], w[N_IN+CW -: CW], w[N_IN], w[N_IN-1:0]);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input logic [N_IN-1:0] rq, input logic [N_IN-1:0] mk,
                      input bit fv, input bit cr);
    bit xfer;
    int win;
    int c;
    exp_q.push_back(model_word());
    rst          = r;
    req_i        = rq;
    mask_i       = mk;
    flit_valid_i = fv;
    credit_ret_i = cr;
    if (r) begin
      model_reset();
    end else begin
      xfer = m_busy && (m_cred > 0) && fv;
      if (xfer && !cr) m_cred = m_cred - 1;
      else if (cr && !xfer) begin
        if (m_cred == CRED) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
      if (!m_busy) begin
        win = -1;
        for (int k = 1; k <= N_IN; k++) begin
          c = (m_last + k) % N_IN;
          if (win < 0 && rq[c] && !mk[c]) win = c;
        end
        if (win >= 0) begin
          m_busy  = 1'b1;
          m_owner = win;
          m_sent  = 0;
          gnt_q.push_back(win);
        end
      end else if (xfer) begin
        m_sent = m_sent + 1;
        if (m_sent == PKT) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n, input logic [N_IN-1:0] rq, input logic [N_IN-1:0] mk,
                       input bit fv, input bit cr);
    for (int i = 0; i < n; i++) step(1'b0, rq, mk, fv, cr);
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    obs_g.delete();
  endtask

  task automatic check_seq(input string name);
    checks++;
    if (obs_g.size() != exp_g.size()) begin
      errors++;
      $display("FAIL %s grant count got %0d exp %0d", name, obs_g.size(), exp_g.size());
    end else begin
      for (int i = 0; i < exp_g.size(); i++) begin
        checks++;
        if (obs_g[i] != exp_g[i]) begin
          errors++;
          $display("FAIL %s grant[%0d] got %0d exp %0d", name, i, obs_g[i], exp_g[i]);
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] e;
    logic         prev_busy;
    int           g;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {busy_o, send_o, grant_idx_o, credit_cnt_o, credit_err_o, grant_o};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs @%0t got %s exp %s", $time, fmt(act), fmt(e));
        end
        if (busy_o === 1'b1 && prev_busy !== 1'b1) begin
          checks++;
          if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL grant_event @%0t got idx %0d exp none", $time, grant_idx_o);
          end else begin
            g = gnt_q.pop_front();
            if (grant_idx_o !== 3'(g)) begin
              errors++;
              $display("FAIL grant_event @%0t got idx %0d exp %0d", $time, grant_idx_o, g);
            end
          end
          obs_g.push_back(int'(grant_idx_o));
        end
        prev_busy = busy_o;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst          = 1'b1;
    req_i        = '0;
    mask_i       = '0;
    flit_valid_i = 1'b0;
    credit_ret_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then two requesters: input 1 first, then input 2.
    do_reset();
    steps(12, 5'b00110, 5'b00000, 1'b1, 1'b1);
    exp_g = '{1, 2};
    check_seq("two_req");

    // All request, input 2 masked: 0,1,3,4,0 with an idle gap each time.
    do_reset();
    steps(27, 5'b11111, 5'b00100, 1'b1, 1'b1);
    exp_g = '{0, 1, 3, 4, 0};
    check_seq("masked_rr");

    // Credit starvation: stall after 4 flits, one return releases flit 5.
    do_reset();
    steps(5, 5'b00001, 5'b00000, 1'b1, 1'b0);
    steps(3, 5'b00001, 5'b00000, 1'b1, 1'b0);
    steps(1, 5'b00001, 5'b00000, 1'b1, 1'b1);
    steps(1, 5'b00000, 5'b00000, 1'b1, 1'b0);
    steps(2, 5'b00000, 5'b00000, 1'b0, 1'b0);
    exp_g = '{0};
    check_seq("starve");

    // Transfer + return at 2 credits, then overflow and sticky error.
    do_reset();
    steps(3, 5'b00001, 5'b00000, 1'b1, 1'b0);
    steps(1, 5'b00001, 5'b00000, 1'b1, 1'b1);
    steps(3, 5'b00001, 5'b00000, 1'b0, 1'b1);
    steps(2, 5'b00001, 5'b00000, 1'b0, 1'b0);

    // Granted input drops its request after flit 2; packet still completes.
    do_reset();
    steps(3, 5'b00010, 5'b00000, 1'b1, 1'b1);
    steps(3, 5'b00000, 5'b11111, 1'b1, 1'b1);
    steps(2, 5'b00000, 5'b00000, 1'b0, 1'b0);
    exp_g = '{1};
    check_seq("req_drop");

    // Reset mid-packet after flit 3.
    do_reset();
    steps(4, 5'b01000, 5'b00000, 1'b1, 1'b0);
    step(1'b1, 5'b01000, 5'b00000, 1'b1, 1'b0);
    steps(2, 5'b00000, 5'b00000, 1'b0, 1'b0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           N_IN'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 0) ? '0 : N_IN'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end
    step(1'b0, '0, '0, 1'b0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (gnt_q.size() > 1) begin
      errors++;
      $display("FAIL gnt_q_drain got %0d left exp <=1", gnt_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_port_sched.md
# out_port_sched

Per-output-port scheduler for the 5-port NoC router. It arbitrates round-robin among the five input ports (N, S, E, W, Local) requesting this output and locks the grant for one fixed-length packet. It gates each flit transfer on downstream buffer credits. One instance sits in front of each output port's crossbar mux. It replaces the vendor arbiter with an in-house picker and adds credit-based flow control.

## Interface
Parameters:
- N_IN, 5, number of requesting input ports (max 7).
- PKT_FLITS, 5, flits per packet, head included.
- CREDITS, 4, downstream buffer depth in flits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- req_i  in  N_IN  per-input request for this output; bit 0 = N, 1 = S, 2 = E, 3 = W, 4 = L.
- mask_i  in  N_IN  1 = input ineligible for a new grant.
- flit_valid_i  in  1  granted input presents a flit this cycle.
- credit_ret_i  in  1  downstream freed one buffer slot.
- grant_o  out  N_IN  one-hot grant, registered.
- grant_idx_o  out  3  index of the granted input; 3'b111 = no grant.
- send_o  out  1  flit transfer permitted this cycle.
- busy_o  out  1  packet lock held.
- credit_cnt_o  out  $clog2(CREDITS+1)  current credits.
- credit_err_o  out  1  sticky credit-overflow error.

## Operation
- FSM has two states:
  - IDLE: grant_o = 0, grant_idx_o = 3'b111.
  - LOCK: grant held.
- Eligible set: req_i & ~mask_i.
- IDLE -> LOCK happens when the eligible set is non-zero.
  - The winner is the first eligible index scanning ptr+1, ptr+2, … with wrap modulo N_IN.
  - The grant registers on the transition, and flit_cnt is cleared to 0.
- send_o = (state == LOCK) && (credit_cnt != 0). This is combinational from the registered state.
- A transfer occurs when send_o && flit_valid_i.
  - Each transfer increments flit_cnt.
  - flit_valid_i is ignored when send_o = 0; no transfer occurs.
- LOCK -> IDLE happens on the transfer with flit_cnt == PKT_FLITS-1. On that transition, ptr <= granted index.
- While in LOCK:
  - Changes to req_i or mask_i have no effect; the grant is held until PKT_FLITS flits have transferred.
  - Deassertion of req_i by the granted input does not release the lock.
- Credit counter behaviour:
  - Transfer alone: −1.
  - credit_ret_i alone: +1.
  - Both in the same cycle: unchanged.
  - credit_ret_i alone at CREDITS: the count stays at CREDITS and credit_err_o sets. It clears only on rst.
- No transfer ever occurs at 0 credits, so underflow cannot happen.
- busy_o = (state == LOCK).

## Timing
- Reset values:
  - state IDLE.
  - grant_o 0, grant_idx_o 3'b111.
  - ptr = N_IN-1, so input 0 has first priority.
  - credit_cnt CREDITS, flit_cnt 0.
  - credit_err_o 0, busy_o 0, send_o 0.
- Reset is honoured mid-packet: the lock is dropped and credits are restored to CREDITS on the next edge.
- Grant latency: an eligible request sampled in IDLE at edge t gives grant_o/busy_o high in the cycle after t.
- Release timing:
  - If the last-flit transfer occurs in cycle t, grant_o = 0 in cycle t+1.
  - The next grant is visible in cycle t+2 at the earliest, giving one mandatory idle cycle between packets.
- Minimum packet occupancy is PKT_FLITS cycles in LOCK, given continuous credits and valid.
- A credit returned in cycle t is usable for send_o in cycle t+1.

## Structure
- Shared package noc_pkg holds:
  - Port index constants (PORT_N = 0 … PORT_L = 4).
  - NO_GRANT = 3'b111.
  - Default PKT_FLITS.
  - The state enum {IDLE, LOCK}.
- Sub-module rr_pick is purely combinational. It takes the eligible vector and ptr, and returns a one-hot grant, an index and any_eligible. It is reused by the future switch allocator.
- Credit counter and flit counter are inline registers.

## Test plan
- Reset, then req_i = 5'b00110 at cycle 1:
  - grant_idx_o = 1 at cycle 2.
  - After 5 transfers, grant_idx_o = 3'b111.
  - Next grant goes to index 2.
- req_i = 5'b11111 held, credits always returned, and mask_i = 5'b00100:
  - Grant sequence is 0, 1, 3, 4, 0.
  - There is one idle cycle between packets.
- No credit returns, flit_valid_i = 1 continuously:
  - send_o drops after 4 transfers; credit_cnt_o = 0.
  - Lock is held.
  - One credit_ret_i pulse gives send_o high the next cycle, and the 5th flit transfers.
- Simultaneous transfer and credit_ret_i at credit_cnt_o = 2:
  - Count stays at 2.
  - credit_ret_i at 4 with no transfer: count stays at 4 and credit_err_o = 1 until rst.
- Granted input drops req_i after flit 2:
  - Lock is held and flits 3–5 still counted.
- rst asserted after flit 3:
  - Next cycle busy_o = 0, grant_idx_o = 3'b111, credit_cnt_o = 4.
